knn_vote: RTL and testbench

- Downstream stage of the KNN core. Consumes the sorted neighbour label list (entry 0 = nearest) and produces the majority-vote classification.
- Counts the labels of the first n valid neighbours into per-class histogram counters, then scans the counters for the winner.
- Sits between the KNN core's neighbour-info output and the software-visible result registers.

---
 rtl/knn_vote.sv | 232 +++++++++++++++++++++++
 tb/tb_knn_vote.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
`default_nettype none
// ============================================================================
//  Module      : knn_vote
//  Description : Majority vote over the sorted KNN neighbour label list.
//                Histograms the labels of the first n valid neighbours,
//                then scans the per-class counters for the winner.
//                Optional macro KNN_VOTE_NEAREST_TIE_EN resolves equal-count
//                ties towards the class owning the nearest neighbour instead
//                of the lowest class index.
//  Revision    : 1.0  initial release
// ============================================================================
module knn_vote #(
    parameter int K       = 10,
    parameter int LABEL_W = 4,
    parameter int N_CLASS = 16,
    parameter int CNT_W   = $clog2(K + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     n_valid,
    input  logic [K*LABEL_W-1:0] labels_in,
    output logic                 busy,
    output logic                 done,
    output logic [LABEL_W-1:0]   class_out,
    output logic [CNT_W-1:0]     votes_out,
    output logic                 tie
);

    localparam int SCAN_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
    localparam logic [CNT_W-1:0]  c_K_CNT    = CNT_W'(K);
    localparam logic [SCAN_W-1:0] c_LAST_CLS = SCAN_W'(N_CLASS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_COUNT = 3'd2,
        S_SCAN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q;
    logic [K*LABEL_W-1:0] labels_q;
    logic [CNT_W-1:0]     n_q;
    logic [CNT_W-1:0]     r_q;
    logic [SCAN_W-1:0]    c_q;
    logic [CNT_W-1:0]     cnt_q [N_CLASS];
    logic [LABEL_W-1:0]   best_cls_q;
    logic [CNT_W-1:0]     best_cnt_q;
    logic                 tie_r_q;
    logic                 done_q;
    logic [LABEL_W-1:0]   class_q;
    logic [CNT_W-1:0]     votes_q;
    logic                 tie_q;

    logic [LABEL_W-1:0]   best_cls_d;
    logic [CNT_W-1:0]     best_cnt_d;
    logic                 tie_r_d;

    logic [CNT_W-1:0]     w_n_clamped;
    logic [LABEL_W-1:0]   w_cur_label;
    logic [CNT_W-1:0]     w_scan_cnt;

`ifdef KNN_VOTE_NEAREST_TIE_EN
    logic [CNT_W-1:0]     first_rank_q [N_CLASS];
    logic [CNT_W-1:0]     best_rank_q;
    logic [CNT_W-1:0]     best_rank_d;
    logic [CNT_W-1:0]     w_scan_rank;
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign class_out = class_q;
    assign votes_out = votes_q;
    assign tie       = tie_q;

    assign w_n_clamped = (n_valid > c_K_CNT) ? c_K_CNT : n_valid;

    // Select the label at the current rank during COUNT
    always_comb begin
        w_cur_label = '0;
        for (int i = 0; i < K; i++) begin
            if (r_q == CNT_W'(i)) begin
                w_cur_label = labels_q[i*LABEL_W +: LABEL_W];
            end
        end
    end

    // Select the counter (and first rank) of the class being scanned
    always_comb begin
        w_scan_cnt = '0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
        w_scan_rank = '0;
`endif
        for (int c = 0; c < N_CLASS; c++) begin
            if (c_q == SCAN_W'(c)) begin
                w_scan_cnt = cnt_q[c];
`ifdef KNN_VOTE_NEAREST_TIE_EN
                w_scan_rank = first_rank_q[c];
`endif
            end
        end
    end

    // Running-best update for one scanned class; a strictly larger count
    // takes over, an equal nonzero count only flags a tie
    always_comb begin
        best_cls_d = best_cls_q;
        best_cnt_d = best_cnt_q;
        tie_r_d    = tie_r_q;
`ifdef KNN_VOTE_NEAREST_TIE_EN
        best_rank_d = best_rank_q;
`endif
        if (w_scan_cnt > best_cnt_q) begin
            best_cls_d = LABEL_W'(c_q);
            best_cnt_d = w_scan_cnt;
            tie_r_d    = 1'b0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
            best_rank_d = w_scan_rank;
`endif
        end else if ((w_scan_cnt == best_cnt_q) && (best_cnt_q != '0)) begin
            tie_r_d = 1'b1;
`ifdef KNN_VOTE_NEAREST_TIE_EN
            if (w_scan_rank < best_rank_q) begin
                best_cls_d  = LABEL_W'(c_q);
                best_rank_d = w_scan_rank;
            end
`endif
        end
    end

    // Control FSM, histogram counters and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            labels_q   <= '0;
            n_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            best_cls_q <= '0;
            best_cnt_q <= '0;
            tie_r_q    <= 1'b0;
            done_q     <= 1'b0;
            class_q    <= '0;
            votes_q    <= '0;
            tie_q      <= 1'b0;
            for (int c = 0; c < N_CLASS; c++) begin
                cnt_q[c] <= '0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
                first_rank_q[c] <= c_K_CNT;
`endif
            end
`ifdef KNN_VOTE_NEAREST_TIE_EN
            best_rank_q <= c_K_CNT;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        labels_q <= labels_in;
                        n_q      <= w_n_clamped;
                        state_q  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    for (int c = 0; c < N_CLASS; c++) begin
                        cnt_q[c] <= '0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
                        first_rank_q[c] <= c_K_CNT;
`endif
                    end
                    best_cls_q <= '0;
                    best_cnt_q <= '0;
                    tie_r_q    <= 1'b0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
                    best_rank_q <= c_K_CNT;
`endif
                    r_q     <= '0;
                    c_q     <= '0;
                    state_q <= (n_q == '0) ? S_SCAN : S_COUNT;
                end
                S_COUNT: begin
                    // Labels outside the class range match no counter and
                    // simply consume their cycle
                    for (int c = 0; c < N_CLASS; c++) begin
                        if (w_cur_label == LABEL_W'(c)) begin
                            cnt_q[c] <= cnt_q[c] + 1'b1;
`ifdef KNN_VOTE_NEAREST_TIE_EN
                            if (cnt_q[c] == '0) begin
                                first_rank_q[c] <= r_q;
                            end
`endif
                        end
                    end
                    if (r_q == (n_q - 1'b1)) begin
                        state_q <= S_SCAN;
                    end else begin
                        r_q <= r_q + 1'b1;
                    end
                end
                S_SCAN: begin
                    best_cls_q <= best_cls_d;
                    best_cnt_q <= best_cnt_d;
                    tie_r_q    <= tie_r_d;
`ifdef KNN_VOTE_NEAREST_TIE_EN
                    best_rank_q <= best_rank_d;
`endif
                    if (c_q == c_LAST_CLS) begin
                        // Results load on the edge into DONE so they are
                        // already valid while done is high
                        class_q <= best_cls_d;
                        votes_q <= best_cnt_d;
                        tie_q   <= tie_r_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        c_q <= c_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_knn_vote.sv
`default_nettype none
// ============================================================================
//  Module      : tb_knn_vote
//  Description : Self-checking bench for knn_vote: directed cases from the
//                test plan followed by randomized label lists, each checked
//                against a histogram reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_knn_vote;

    localparam int K  = 10;
    localparam int LW = 4;
    localparam int NC = 16;
    localparam int CW = 4;

    logic            clk;
    logic            rst;
    logic            start;
    logic [CW-1:0]   n_valid;
    logic [K*LW-1:0] labels_in;
    logic            busy;
    logic            done;
    logic [LW-1:0]   class_out;
    logic [CW-1:0]   votes_out;
    logic            tie;

    int checks = 0;
    int errors = 0;

    knn_vote #(
        .K       (K),
        .LABEL_W (LW),
        .N_CLASS (NC),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_valid   (n_valid),
        .labels_in (labels_in),
        .busy      (busy),
        .done      (done),
        .class_out (class_out),
        .votes_out (votes_out),
        .tie       (tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [K*LW-1:0] pack(input int a [K]);
        logic [K*LW-1:0] v;
        v = '0;
        for (int i = 0; i < K; i++) v[i*LW +: LW] = LW'(a[i]);
        return v;
    endfunction

    // Reference: histogram of the first n labels, pick the maximum count;
    // ties go to the lowest class, or to the class seen first in the list
    task automatic model(input logic [K*LW-1:0] lv, input int nv,
                         output int cls, output int votes, output int tf);
        int n;
        int h [NC];
        int fr [NC];
        int nmax;
        n = (nv > K) ? K : nv;
        for (int c = 0; c < NC; c++) begin
            h[c]  = 0;
            fr[c] = K;
        end
        for (int i = 0; i < n; i++) begin
            int l;
            l = int'(lv[i*LW +: LW]);
            if (l < NC) begin
                if (h[l] == 0) fr[l] = i;
                h[l]++;
            end
        end
        votes = 0;
        for (int c = 0; c < NC; c++) if (h[c] > votes) votes = h[c];
        nmax = 0;
        cls  = -1;
        for (int c = 0; c < NC; c++) begin
            if (votes > 0 && h[c] == votes) begin
                nmax++;
`ifdef KNN_VOTE_NEAREST_TIE_EN
                if (cls < 0 || fr[c] < fr[cls]) cls = c;
`else
                if (cls < 0) cls = c;
`endif
            end
        end
        if (cls < 0) cls = 0;
        tf = (nmax > 1) ? 1 : 0;
    endtask

    // One run: start in cycle 0, watch done/busy, compare with the model.
    // With disturb set, start is pulsed again in cycle 5 and the inputs
    // change in cycle 6; the run is then watched longer for a stray done.
    task automatic run_case(input string name, input logic [K*LW-1:0] lv,
                            input logic [CW-1:0] nv, input bit disturb,
                            output int ocls, output int ovotes,
                            output int otie, output int ocyc);
        int ecls, evotes, etie, lat, last, ndone;
        bit busy_ok;
        model(lv, int'(nv), ecls, evotes, etie);
        lat     = ((int'(nv) > K) ? K : int'(nv)) + NC + 2;
        last    = lat + (disturb ? 20 : 1);
        ndone   = 0;
        busy_ok = 1'b1;
        ocls = 0; ovotes = 0; otie = 0; ocyc = -1;
        labels_in = lv;
        n_valid   = nv;
        start     = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                ocyc   = k;
                ocls   = int'(class_out);
                ovotes = int'(votes_out);
                otie   = int'(tie);
            end
            if (busy !== (k <= lat)) busy_ok = 1'b0;
            if (k == 1) start = 1'b0;
            if (disturb && k == 5) start = 1'b1;
            if (disturb && k == 6) begin
                start     = 1'b0;
                labels_in = ~lv;
                n_valid   = 4'd3;
            end
        end
        check({name, "/done_count"}, ndone, 1);
        check({name, "/done_cycle"}, ocyc, lat);
        check({name, "/busy"}, busy_ok, 1);
        check({name, "/class"}, ocls, ecls);
        check({name, "/votes"}, ovotes, evotes);
        check({name, "/tie"}, otie, etie);
    endtask

    initial begin
        int arr [K];
        logic [K*LW-1:0] lv;
        int gc, gv, gt, gy, nd;
        bit idle_ok;

        rst       = 1'b1;
        start     = 1'b0;
        n_valid   = '0;
        labels_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: nothing moves without start
        idle_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
        end
        check("reset/idle_quiet", idle_ok, 1);
        check("reset/class", class_out, 0);
        check("reset/votes", votes_out, 0);
        check("reset/tie", tie, 0);

        // Clear majority
        arr = '{3, 3, 5, 3, 1, 5, 3, 2, 3, 0};
        lv  = pack(arr);
        run_case("majority", lv, 4'd10, 1'b0, gc, gv, gt, gy);
        check("majority/spec_class", gc, 3);
        check("majority/spec_votes", gv, 5);
        check("majority/spec_tie", gt, 0);
        check("majority/spec_cycle", gy, 28);

        // Two-way tie
        arr = '{7, 2, 7, 2, 9, 9, 9, 9, 9, 9};
        lv  = pack(arr);
        run_case("tie", lv, 4'd4, 1'b0, gc, gv, gt, gy);
`ifdef KNN_VOTE_NEAREST_TIE_EN
        check("tie/spec_class", gc, 7);
`else
        check("tie/spec_class", gc, 2);
`endif
        check("tie/spec_votes", gv, 2);
        check("tie/spec_tie", gt, 1);

        // Partial list
        arr = '{4, 4, 1, 1, 1, 1, 1, 1, 1, 1};
        lv  = pack(arr);
        run_case("partial", lv, 4'd3, 1'b0, gc, gv, gt, gy);
        check("partial/spec_class", gc, 4);
        check("partial/spec_votes", gv, 2);
        check("partial/spec_cycle", gy, 21);

        // Reset in cycle 10 of a run aborts it
        arr = '{6, 6, 6, 1, 1, 2, 2, 3, 3, 6};
        labels_in = pack(arr);
        n_valid   = 4'd10;
        start     = 1'b1;
        nd        = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
            if (k == 1) start = 1'b0;
            if (k == 10) rst = 1'b1;
            if (k == 11) begin
                check("midreset/busy", busy, 0);
                check("midreset/done", done, 0);
                check("midreset/class", class_out, 0);
                check("midreset/votes", votes_out, 0);
                check("midreset/tie", tie, 0);
                rst = 1'b0;
            end
        end
        check("midreset/no_done", nd, 0);
        run_case("after_reset", pack(arr), 4'd10, 1'b0, gc, gv, gt, gy);

        // Empty list
        for (int i = 0; i < K; i++) arr[i] = 5;
        lv = pack(arr);
        run_case("empty", lv, 4'd0, 1'b0, gc, gv, gt, gy);
        check("empty/spec_class", gc, 0);
        check("empty/spec_votes", gv, 0);
        check("empty/spec_tie", gt, 0);
        check("empty/spec_cycle", gy, 18);

        // n_valid above K is clamped
        arr = '{8, 1, 8, 1, 8, 1, 8, 1, 9, 9};
        lv  = pack(arr);
        run_case("clamp", lv, 4'd12, 1'b0, gc, gv, gt, gy);
        check("clamp/spec_cycle", gy, 28);

        // Start while busy and input change after capture
        arr = '{3, 3, 5, 3, 1, 5, 3, 2, 3, 0};
        lv  = pack(arr);
        run_case("busy_start", lv, 4'd10, 1'b1, gc, gv, gt, gy);
        check("busy_start/spec_class", gc, 3);
        check("busy_start/spec_votes", gv, 5);

        // Randomized lists, including clamped and empty counts
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < K; i++) begin
                if (t < 12) arr[i] = int'($urandom_range(0, 3));
                else        arr[i] = int'($urandom_range(0, NC - 1));
            end
            run_case($sformatf("rand%0d", t), pack(arr),
                     CW'($urandom_range(0, 15)), 1'b0, gc, gv, gt, gy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
